// File: rtl/tl_pkg.sv
// Shared TileLink definitions for the crossbar: default widths, Channel-A opcodes,
// the source-ID type and a small round-robin index helper.
package tl_pkg;

    localparam int TL_SRC_WIDTH       = 2;
    localparam int TL_MAX_OUTSTANDING = 4;
    localparam int TL_CNT_WIDTH       = $clog2(TL_MAX_OUTSTANDING + 1);

    localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_A_ARITHMETIC  = 3'd2;
    localparam logic [2:0] TL_A_LOGICAL     = 3'd3;
    localparam logic [2:0] TL_A_GET         = 3'd4;
    localparam logic [2:0] TL_A_INTENT      = 3'd5;
    localparam logic [2:0] TL_A_ACQUIRE     = 3'd6;

    typedef logic [TL_SRC_WIDTH-1:0] tl_src_t;

    // Next index in a ring of n entries
    function automatic int tl_wrap_next(input int idx, input int n);
        return ((idx + 32'sd1) >= n) ? 32'sd0 : (idx + 32'sd1);
    endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after i_start,
// wrapping around the N entries.
module tl_rr_pick #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    output logic         o_hit,
    output logic [W-1:0] o_idx
);

    // Scan offsets 0..N-1 from the start index; the first requester wins
    always_comb begin
        o_hit = 1'b0;
        o_idx = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!o_hit && i_req[j] &&
                    ((int'(i_start) + i == j) || (int'(i_start) + i == j + N))) begin
                    o_hit = 1'b1;
                    o_idx = W'(j);
                end else begin
                    o_hit = o_hit;
                end
            end
        end
    end

endmodule

// File: rtl/tl_a_credit_scheduler.sv
// Channel-A grant controller: round-robin grant held until handshake, per-master
// credit counters retired by Channel-D responses, and a drain handshake.
module tl_a_credit_scheduler
    import tl_pkg::*;
#(
    parameter int NUM_MASTERS     = 3,
    parameter int SRC_WIDTH       = TL_SRC_WIDTH,
    parameter int MAX_OUTSTANDING = TL_MAX_OUTSTANDING,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_MASTERS-1:0]           a_valid,
    output logic [NUM_MASTERS-1:0]           a_ready,
    output logic                             a_valid_out,
    input  logic                             a_ready_out,
    output logic                             grant_vld,
    output logic [SRC_WIDTH-1:0]             grant_idx,
    output logic [NUM_MASTERS-1:0]           grant_onehot,
    input  logic                             d_valid_in,
    input  logic                             d_ready_in,
    input  logic [SRC_WIDTH-1:0]             d_source_in,
    output logic [NUM_MASTERS*CNT_WIDTH-1:0] outstanding,
    input  logic                             drain_req,
    output logic                             drain_done,
    output logic                             err_unexpected_d,
    output logic [SRC_WIDTH-1:0]             err_src
);

    logic                   r_grant_vld;
    logic [SRC_WIDTH-1:0]   r_grant_idx;
    logic [CNT_WIDTH-1:0]   r_cnt [NUM_MASTERS];
    logic                   r_err;
    logic [SRC_WIDTH-1:0]   r_err_src;

    logic                   w_a_fire;
    logic                   w_d_fire;
    logic                   w_gnt_a_valid;
    logic                   w_d_src_ok;
    logic                   w_d_cnt_nz;
    logic                   w_d_legal;
    logic                   w_all_zero;
    logic                   w_hold;
    logic                   w_pick_hit;
    logic [SRC_WIDTH-1:0]   w_pick_idx;
    logic [SRC_WIDTH-1:0]   w_rr_start;
    logic                   w_grant_vld_nxt;
    logic [SRC_WIDTH-1:0]   w_grant_idx_nxt;
    logic [NUM_MASTERS-1:0] w_inc;
    logic [NUM_MASTERS-1:0] w_dec;
    logic [NUM_MASTERS-1:0] w_elig;
    logic [CNT_WIDTH:0]     w_eff [NUM_MASTERS];

    assign a_valid_out = r_grant_vld & w_gnt_a_valid;
    assign w_a_fire    = a_valid_out & a_ready_out;
    assign w_d_fire    = d_valid_in & d_ready_in;
    assign w_d_src_ok  = (int'(d_source_in) < NUM_MASTERS);
    assign w_d_legal   = w_d_fire & w_d_src_ok & w_d_cnt_nz;
    assign w_hold      = r_grant_vld & w_gnt_a_valid & ~a_ready_out;
    assign w_rr_start  = SRC_WIDTH'(tl_wrap_next(int'(r_grant_idx), NUM_MASTERS));

    // Index-based lookups into the per-master vectors, out-of-range indices read as 0
    always_comb begin
        w_gnt_a_valid = 1'b0;
        w_d_cnt_nz    = 1'b0;
        w_all_zero    = 1'b1;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            w_gnt_a_valid = w_gnt_a_valid | (a_valid[m] & (r_grant_idx == SRC_WIDTH'(m)));
            w_d_cnt_nz    = w_d_cnt_nz | ((d_source_in == SRC_WIDTH'(m)) &&
                                          (r_cnt[m] != {CNT_WIDTH{1'b0}}));
            w_all_zero    = w_all_zero & (r_cnt[m] == {CNT_WIDTH{1'b0}});
        end
    end

    // Per-master credit events, eligibility and derived outputs
    always_comb begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
            w_inc[m]        = w_a_fire & (r_grant_idx == SRC_WIDTH'(m));
            w_dec[m]        = w_d_legal & (d_source_in == SRC_WIDTH'(m));
            // Counting this cycle's fires keeps a master from overshooting its limit
            w_eff[m]        = {1'b0, r_cnt[m]} + {{CNT_WIDTH{1'b0}}, w_inc[m]}
                                               - {{CNT_WIDTH{1'b0}}, w_dec[m]};
            w_elig[m]       = a_valid[m] & ~drain_req &
                              (w_eff[m] < (CNT_WIDTH+1)'(MAX_OUTSTANDING));
            a_ready[m]      = r_grant_vld & (r_grant_idx == SRC_WIDTH'(m)) & a_ready_out;
            grant_onehot[m] = r_grant_vld & (r_grant_idx == SRC_WIDTH'(m));
            outstanding[m*CNT_WIDTH +: CNT_WIDTH] = r_cnt[m];
        end
    end

    tl_rr_pick #(
        .N (NUM_MASTERS),
        .W (SRC_WIDTH)
    ) u_rr_pick (
        .i_req   (w_elig),
        .i_start (w_rr_start),
        .o_hit   (w_pick_hit),
        .o_idx   (w_pick_idx)
    );

    // Grant next state: hold mid-request, otherwise re-arbitrate; idle keeps the RR pointer
    always_comb begin
        w_grant_vld_nxt = r_grant_vld;
        w_grant_idx_nxt = r_grant_idx;
        if (w_hold) begin
            w_grant_vld_nxt = 1'b1;
            w_grant_idx_nxt = r_grant_idx;
        end else if (w_pick_hit) begin
            w_grant_vld_nxt = 1'b1;
            w_grant_idx_nxt = w_pick_idx;
        end else begin
            w_grant_vld_nxt = 1'b0;
            w_grant_idx_nxt = r_grant_idx;
        end
    end

    // Grant register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant_vld <= 1'b0;
            r_grant_idx <= SRC_WIDTH'(NUM_MASTERS - 1);
        end else begin
            r_grant_vld <= w_grant_vld_nxt;
            r_grant_idx <= w_grant_idx_nxt;
        end
    end

    // Credit counters, saturating at both ends
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                r_cnt[m] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (w_inc[m] && !w_dec[m] && (r_cnt[m] != CNT_WIDTH'(MAX_OUTSTANDING))) begin
                    r_cnt[m] <= r_cnt[m] + CNT_WIDTH'(1);
                end else if (w_dec[m] && !w_inc[m] && (r_cnt[m] != {CNT_WIDTH{1'b0}})) begin
                    r_cnt[m] <= r_cnt[m] - CNT_WIDTH'(1);
                end else begin
                    r_cnt[m] <= r_cnt[m];
                end
            end
        end
    end

    // Sticky illegal-D flag; source captured only on the first occurrence
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err     <= 1'b0;
            r_err_src <= {SRC_WIDTH{1'b0}};
        end else if (w_d_fire && !w_d_legal) begin
            r_err     <= 1'b1;
            r_err_src <= r_err ? r_err_src : d_source_in;
        end else begin
            r_err     <= r_err;
            r_err_src <= r_err_src;
        end
    end

    assign grant_vld        = r_grant_vld;
    assign grant_idx        = r_grant_idx;
    assign err_unexpected_d = r_err;
    assign err_src          = r_err_src;
    assign drain_done       = drain_req & ~r_grant_vld & w_all_zero;

endmodule

// File: tb/tb_tl_a_credit_scheduler.sv
// Directed bench for tl_a_credit_scheduler with a scoreboard of expected A-fire sources.
module tb_tl_a_credit_scheduler;

    localparam int NM = 3;
    localparam int SW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NM-1:0] a_valid;
    logic [NM-1:0] a_ready;
    logic          a_valid_out;
    logic          a_ready_out;
    logic          grant_vld;
    logic [SW-1:0] grant_idx;
    logic [NM-1:0] grant_onehot;
    logic          d_valid_in;
    logic          d_ready_in;
    logic [SW-1:0] d_source_in;
    logic [NM*CW-1:0] outstanding;
    logic          drain_req;
    logic          drain_done;
    logic          err_unexpected_d;
    logic [SW-1:0] err_src;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    tl_a_credit_scheduler dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .a_valid          (a_valid),
        .a_ready          (a_ready),
        .a_valid_out      (a_valid_out),
        .a_ready_out      (a_ready_out),
        .grant_vld        (grant_vld),
        .grant_idx        (grant_idx),
        .grant_onehot     (grant_onehot),
        .d_valid_in       (d_valid_in),
        .d_ready_in       (d_ready_in),
        .d_source_in      (d_source_in),
        .outstanding      (outstanding),
        .drain_req        (drain_req),
        .drain_done       (drain_done),
        .err_unexpected_d (err_unexpected_d),
        .err_src          (err_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        a_valid     = 3'b000;
        a_ready_out = 1'b0;
        d_valid_in  = 1'b0;
        d_ready_in  = 1'b0;
        d_source_in = 2'd0;
        drain_req   = 1'b0;
        cyc();
        cyc();
    endtask

    function automatic logic [31:0] cnt_of(input int m);
        return 32'(outstanding[m*CW +: CW]);
    endfunction

    // Scoreboard: every A handshake must match the next expected source
    always @(negedge clk) begin
        if (reset_n === 1'b1 && a_valid_out === 1'b1 && a_ready_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_fire", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("sb_fire_src", 32'(grant_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // 1. Reset defaults and first round-robin pass
        reset_n = 1'b0; a_valid = 3'b111; a_ready_out = 1'b1;
        d_valid_in = 1'b0; d_ready_in = 1'b0; d_source_in = 2'd0; drain_req = 1'b0;
        cyc(); cyc();
        chk("rst_grant_vld", 32'(grant_vld), 32'd0);
        chk("rst_grant_idx", 32'(grant_idx), 32'd2);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_a_valid_out", 32'(a_valid_out), 32'd0);
        chk("rst_onehot", 32'(grant_onehot), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err", 32'(err_unexpected_d), 32'd0);
        chk("rst_err_src", 32'(err_src), 32'd0);
        chk("rst_drain_done0", 32'(drain_done), 32'd0);
        drain_req = 1'b1; #1;
        chk("rst_drain_done1", 32'(drain_done), 32'd1);
        drain_req = 1'b0; #1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        reset_n = 1'b1;
        cyc();
        chk("rr_first_vld", 32'(grant_vld), 32'd1);
        chk("rr_first_idx", 32'(grant_idx), 32'd0);
        chk("rr_first_aout", 32'(a_valid_out), 32'd1);
        chk("rr_first_ready", 32'(a_ready), 32'b001);
        chk("rr_first_onehot", 32'(grant_onehot), 32'b001);
        cyc();
        chk("rr_second_idx", 32'(grant_idx), 32'd1);
        chk("rr_cnt0", cnt_of(0), 32'd1);
        cyc();
        chk("rr_third_idx", 32'(grant_idx), 32'd2);
        chk("rr_cnt1", cnt_of(1), 32'd1);
        a_valid = 3'b100;
        cyc();
        a_valid = 3'b000; #1;
        chk("rr_cnt2", cnt_of(2), 32'd1);
        chk("rr_drop_aout", 32'(a_valid_out), 32'd0);
        cyc();
        chk("rr_idle_vld", 32'(grant_vld), 32'd0);
        chk("rr_idle_ptr", 32'(grant_idx), 32'd2);
        chk("rr_all_cnt", 32'(outstanding), 32'b001_001_001);

        // 2. Grant lock while a_ready_out is low
        do_reset();
        a_valid = 3'b010; reset_n = 1'b1;
        cyc();
        chk("lock_vld", 32'(grant_vld), 32'd1);
        chk("lock_idx0", 32'(grant_idx), 32'd1);
        a_valid = 3'b111;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("lock_idx", 32'(grant_idx), 32'd1);
            chk("lock_no_ready", 32'(a_ready), 32'd0);
        end
        a_ready_out = 1'b1; exp_q.push_back(1); #1;
        chk("lock_ready1", 32'(a_ready), 32'b010);
        cyc();
        chk("lock_next_idx", 32'(grant_idx), 32'd2);
        chk("lock_cnt1", cnt_of(1), 32'd1);
        a_valid = 3'b000; a_ready_out = 1'b0;
        cyc();
        chk("drop_loses_grant", 32'(grant_vld), 32'd0);

        // 3. Credit limit
        do_reset();
        a_valid = 3'b001; a_ready_out = 1'b1; reset_n = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(0);
        cyc();
        chk("cred_grant", 32'(grant_idx), 32'd0);
        repeat (4) cyc();
        chk("cred_full_vld", 32'(grant_vld), 32'd0);
        chk("cred_full_cnt", cnt_of(0), 32'd4);
        cyc();
        chk("cred_block_vld", 32'(grant_vld), 32'd0);
        chk("cred_block_cnt", cnt_of(0), 32'd4);
        d_valid_in = 1'b1; d_ready_in = 1'b1; d_source_in = 2'd0;
        cyc();
        chk("cred_ret_cnt", cnt_of(0), 32'd3);
        chk("cred_regrant_vld", 32'(grant_vld), 32'd1);
        chk("cred_regrant_idx", 32'(grant_idx), 32'd0);
        d_valid_in = 1'b0; a_valid = 3'b000;
        cyc();
        chk("cred_idle", 32'(grant_vld), 32'd0);
        chk("cred_no_err", 32'(err_unexpected_d), 32'd0);

        // 4. Simultaneous A and D fire on master 2
        do_reset();
        a_valid = 3'b100; a_ready_out = 1'b1; reset_n = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(2);
        cyc(); cyc(); cyc();
        chk("sim_pre_cnt", cnt_of(2), 32'd2);
        d_valid_in = 1'b1; d_ready_in = 1'b1; d_source_in = 2'd2;
        cyc();
        a_valid = 3'b000; d_valid_in = 1'b0;
        chk("sim_cnt", cnt_of(2), 32'd2);
        chk("sim_no_err", 32'(err_unexpected_d), 32'd0);
        cyc();
        chk("sim_cnt_after", cnt_of(2), 32'd2);

        // 5. Illegal D responses and a D without ready
        d_valid_in = 1'b1; d_ready_in = 1'b0; d_source_in = 2'd2;
        cyc();
        chk("d_noready_cnt", cnt_of(2), 32'd2);
        d_ready_in = 1'b1; d_source_in = 2'd3;
        cyc();
        d_valid_in = 1'b0;
        chk("ill_src_err", 32'(err_unexpected_d), 32'd1);
        chk("ill_src_id", 32'(err_src), 32'd3);
        chk("ill_src_cnts", 32'(outstanding), 32'b010_000_000);
        d_valid_in = 1'b1; d_source_in = 2'd1;
        cyc();
        d_valid_in = 1'b0;
        chk("ill_zero_err", 32'(err_unexpected_d), 32'd1);
        chk("ill_zero_src", 32'(err_src), 32'd3);
        chk("ill_zero_cnts", 32'(outstanding), 32'b010_000_000);

        // Asynchronous reset mid-transfer discards state
        a_valid = 3'b100; a_ready_out = 1'b0;
        cyc();
        chk("mid_held", 32'(grant_vld), 32'd1);
        reset_n = 1'b0; #1;
        chk("mid_rst_vld", 32'(grant_vld), 32'd0);
        chk("mid_rst_cnts", 32'(outstanding), 32'd0);
        chk("mid_rst_err", 32'(err_unexpected_d), 32'd0);
        chk("mid_rst_src", 32'(err_src), 32'd0);

        // 6. Drain
        do_reset();
        a_valid = 3'b001; reset_n = 1'b1;
        cyc();
        drain_req = 1'b1; a_valid = 3'b011; #1;
        chk("drain_busy", 32'(drain_done), 32'd0);
        cyc(); cyc();
        chk("drain_held_idx", 32'(grant_idx), 32'd0);
        chk("drain_held_vld", 32'(grant_vld), 32'd1);
        a_ready_out = 1'b1; exp_q.push_back(0);
        cyc();
        chk("drain_no_regrant", 32'(grant_vld), 32'd0);
        chk("drain_cnt", cnt_of(0), 32'd1);
        chk("drain_wait_d", 32'(drain_done), 32'd0);
        cyc();
        chk("drain_still_idle", 32'(grant_vld), 32'd0);
        d_valid_in = 1'b1; d_ready_in = 1'b1; d_source_in = 2'd0;
        cyc();
        d_valid_in = 1'b0; #1;
        chk("drain_cnt_zero", cnt_of(0), 32'd0);
        chk("drain_done", 32'(drain_done), 32'd1);
        drain_req = 1'b0; #1;
        chk("drain_release", 32'(drain_done), 32'd0);
        cyc();
        chk("resume_vld", 32'(grant_vld), 32'd1);
        chk("resume_idx", 32'(grant_idx), 32'd1);
        a_ready_out = 1'b0; a_valid = 3'b000;
        cyc();

        chk("sb_pending", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tl_a_credit_scheduler.md
# tl_a_credit_scheduler

Channel-A grant controller for the 3-master TileLink crossbar. Shares the single downstream A port (toward the CDC adapter) between masters with round-robin order and a grant held until handshake. Limits each master's in-flight requests with per-source credit counters retired by Channel-D responses. Drives the crossbar's A-side mux select and per-master `a_ready`, and provides a drain handshake for quiescing the CDC path.

## Interface
- `NUM_MASTERS`, 3: number of requesters; also the legal source ID range 0..NUM_MASTERS-1.
- `SRC_WIDTH`, 2: width of the source/grant index; must satisfy 2^SRC_WIDTH >= NUM_MASTERS.
- `MAX_OUTSTANDING`, 4: maximum in-flight A requests per master; must be >= 1.
- `CNT_WIDTH`, $clog2(MAX_OUTSTANDING+1): width of each credit counter.

- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `a_valid` in NUM_MASTERS: per-master A request valid.
- `a_ready` out NUM_MASTERS: per-master A ready.
- `a_valid_out` out 1: A valid toward the CDC adapter.
- `a_ready_out` in 1: A ready from the CDC adapter.
- `grant_vld` out 1: a grant is currently held.
- `grant_idx` out SRC_WIDTH: index of the granted master; also the crossbar mux select and outgoing `a_source`.
- `grant_onehot` out NUM_MASTERS: one-hot form of the grant; all zeros when `grant_vld`=0.
- `d_valid_in` in 1: D response valid.
- `d_ready_in` in 1: D response ready, as routed to the master.
- `d_source_in` in SRC_WIDTH: source ID of the D response.
- `outstanding` out NUM_MASTERS*CNT_WIDTH: per-master in-flight count; master m occupies bits [m*CNT_WIDTH +: CNT_WIDTH].
- `drain_req` in 1: stop issuing new grants.
- `drain_done` out 1: drain complete.
- `err_unexpected_d` out 1: sticky flag for an illegal D response.
- `err_src` out SRC_WIDTH: source ID of the first illegal D response.

## Operation
- **Fire events**
  - `a_fire` = `a_valid_out` & `a_ready_out`.
  - `d_fire` = `d_valid_in` & `d_ready_in`.
- **Combinational outputs**
  - `a_valid_out` = `grant_vld` & `a_valid[grant_idx]`.
  - `a_ready[m]` = `grant_vld` & (`grant_idx`==m) & `a_ready_out`.
- **Eligibility**
  - Master m is eligible when all of the following hold: `a_valid[m]`, `drain_req`=0, and its effective count < MAX_OUTSTANDING.
  - Effective count = `outstanding[m]`, plus 1 if m fires A this cycle, minus 1 if a legal `d_fire` retires m this cycle.
- **Grant next-state**
  - Hold: `grant_vld` & `a_valid[grant_idx]` & !`a_ready_out`. The grant never moves mid-request.
  - Otherwise re-arbitrate. Search eligible masters starting at (`grant_idx`+1) mod NUM_MASTERS, wrapping around.
    - First hit: `grant_vld`<=1, `grant_idx`<=hit.
    - No hit: `grant_vld`<=0, `grant_idx` unchanged so it keeps acting as the RR pointer.
  - A granted master that drops `a_valid` without firing loses the grant on the next edge.
- **Credit counters**
  - Increment on `a_fire` for `grant_idx`.
  - Decrement on a legal `d_fire` for `d_source_in`.
  - Both events on the same master in the same cycle: count unchanged.
  - Counts saturate at 0 and MAX_OUTSTANDING; no wrap in either direction.
- **Illegal D response**
  - Condition: `d_fire` with `d_source_in` >= NUM_MASTERS, or with that master's count == 0.
  - No counter changes.
  - `err_unexpected_d`<=1, sticky until reset.
  - `err_src` captures `d_source_in` only on the first occurrence.
- **Drain**
  - `drain_req` blocks new grants only; a held grant still completes.
  - `drain_done` = `drain_req` & !`grant_vld` & (all counts == 0), combinational.
  - Deasserting `drain_req` resumes arbitration on the next edge.

## Timing
- **Reset values** (reset_n=0):
  - `grant_vld`=0, `grant_idx`=NUM_MASTERS-1, so the first search starts at master 0.
  - All counts 0, `err_unexpected_d`=0, `err_src`=0.
  - Derived outputs follow: `a_ready`=0, `a_valid_out`=0, `grant_onehot`=0. `drain_done` equals `drain_req`.
- **Reset assertion mid-transfer:** all state clears immediately; in-flight credits are discarded.
- **Grant latency:** `a_valid[m]` rising at edge t (no current grant) gives `grant_vld`/`grant_idx` at t+1, with `a_valid_out` at t+1.
- **Throughput:** after an `a_fire` at edge t, the next grant, to the same or a different master, is valid from t+1. Back-to-back fires are possible with zero bubbles.
- **Counter update:** `outstanding` reflects an A or D fire one edge after it.

## Structure
- Shared package `tl_pkg`:
  - width parameters SRC_WIDTH and CNT_WIDTH defaults;
  - TileLink opcode localparams;
  - a `tl_src_t` typedef.
- Sub-module `tl_rr_pick`: combinational round-robin picker.
  - Inputs: request vector and start index.
  - Outputs: hit flag and index.
  - Reusable for the future D-channel arbiter.
- Top level owns:
  - the grant register;
  - the credit counter array;
  - the error capture;
  - the drain logic.

## Test plan
1. **Reset defaults:** hold reset_n=0 with `a_valid`=3'b111 → `grant_vld`=0, `a_ready`=0, all counts 0. Release reset → master 0 granted first, then 1, then 2 with `a_ready_out`=1 each cycle.
2. **Grant lock:** master 1 valid with `a_ready_out`=0 for 5 cycles, masters 0 and 2 also valid → `grant_idx`=1 throughout. Fire on cycle 6 → next grant is 2.
3. **Credit limit:** MAX_OUTSTANDING=4; master 0 fires 4 times with no D → count=4, master 0 ineligible. One D fire with source 0 → count 3, master 0 granted again.
4. **Simultaneous events:** A fire and D fire for master 2 in the same cycle with count 2 → count stays 2. No error.
5. **Illegal D:**
   - D fire with source 3 → `err_unexpected_d`=1, `err_src`=3, counts unchanged.
   - Later D fire with source 1 at count 0 → `err_src` stays 3.
6. **Drain:** `drain_req`=1 during a held grant → that request completes, no further grants. `drain_done` rises only after the last D response retires the count to zero.
